// File: rtl/mul_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul_ctrl_if -- EX-stage <-> multiplier control bundle.
//
// Handshake semantics (the only place they are written down):
//   The EX stage (master) raises mul_valid with mul_signed/mul_op1/mul_op2
//   while a multiply sits in EX. The multiplier (slave) takes the request on
//   the first rising edge where it is idle, mul_valid=1 and flush=0. It then
//   raises mul_busy while computing. When mul_ready=1, mul_result holds the
//   128-bit product for the instruction in EX. The result stays presented
//   until the first edge with ex_stall=0, which is when the instruction leaves
//   EX. flush=1 kills the instruction in EX on the next edge; a killed
//   instruction never sees mul_ready.
//
// Signals:
//   mul_valid   master->slave  multiply instruction present in EX
//   mul_signed  master->slave  1 = both operands signed
//   mul_op1     master->slave  64-bit multiplicand
//   mul_op2     master->slave  64-bit multiplier
//   ex_stall    master->slave  EX held by another source
//   flush       master->slave  kill the instruction in EX
//   mul_ready   slave->master  mul_result valid for the instruction in EX
//   mul_result  slave->master  full 128-bit product
//   mul_busy    slave->master  multiplier is iterating
// ---------------------------------------------------------------------------
interface mul_ctrl_if;
  logic         mul_valid;
  logic         mul_signed;
  logic [63:0]  mul_op1;
  logic [63:0]  mul_op2;
  logic         ex_stall;
  logic         flush;
  logic         mul_ready;
  logic [127:0] mul_result;
  logic         mul_busy;

  modport master (
    output mul_valid, mul_signed, mul_op1, mul_op2, ex_stall, flush,
    input  mul_ready, mul_result, mul_busy
  );

  modport slave (
    input  mul_valid, mul_signed, mul_op1, mul_op2, ex_stall, flush,
    output mul_ready, mul_result, mul_busy
  );
endinterface

// File: rtl/mul_ctrl.sv
// ---------------------------------------------------------------------------
// mul_ctrl -- iterative 64x64 -> 128 radix-2 shift-add multiplier for EX.
//
// Operands are converted to magnitudes on accept, multiplied unsigned in
// BUSY (one multiplier bit per edge), and the product is sign-corrected when
// it is loaded into the result register on entry to DONE.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous active-low reset
//   bus          mul_ctrl_if.slave handshake/data bundle
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Configuration macro:
//   MUL_EARLY_EXIT_EN  when defined, BUSY also ends as soon as the shifted
//                      multiplier runs out of set bits; when undefined every
//                      multiply takes exactly 64 BUSY edges.
// ---------------------------------------------------------------------------
module mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  mul_ctrl_if.slave   bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [127:0] r_mcand;
  logic [63:0]  r_mplier;
  logic [127:0] r_acc;
  logic [5:0]   r_cnt;
  logic         r_sign;
  logic [127:0] r_result;

  logic         w_accept;
  logic         w_last;
  logic [63:0]  w_mag1;
  logic [63:0]  w_mag2;
  logic [63:0]  w_mplier_shr;
  logic [127:0] w_acc_add;
  logic [127:0] w_product;

  assign w_accept = (r_state == S_IDLE) && bus.mul_valid && !bus.flush;

  // -2^63 negates to itself, which read as unsigned is the magnitude 2^63.
  assign w_mag1 = (bus.mul_signed && bus.mul_op1[63]) ? (~bus.mul_op1 + 64'd1) : bus.mul_op1;
  assign w_mag2 = (bus.mul_signed && bus.mul_op2[63]) ? (~bus.mul_op2 + 64'd1) : bus.mul_op2;

  assign w_acc_add    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = {1'b0, r_mplier[63:1]};

  // w_last marks the edge that completes the final iteration.
`ifdef MUL_EARLY_EXIT_EN
  assign w_last = (r_cnt == 6'd63) || (w_mplier_shr == 64'd0);
`else
  assign w_last = (r_cnt == 6'd63);
`endif

  // Product including this edge's add, sign-corrected for the result load.
  assign w_product = r_sign ? (~w_acc_add + 128'd1) : w_acc_add;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        if (bus.flush)   w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        // The instruction leaves EX on the first unstalled edge; a new
        // request is only looked at once back in IDLE.
        if (bus.flush || !bus.ex_stall) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= {64'd0, w_mag1};
      r_mplier <= w_mag2;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= bus.mul_signed & (bus.mul_op1[63] ^ bus.mul_op2[63]);
    end else if ((r_state == S_BUSY) && !bus.flush) begin
      r_acc    <= w_acc_add;
      r_mcand  <= {r_mcand[126:0], 1'b0};
      r_mplier <= w_mplier_shr;
      r_cnt    <= r_cnt + 6'd1;
      if (w_last) r_result <= w_product;
    end
  end

  assign bus.mul_ready  = (r_state == S_DONE);
  assign bus.mul_busy   = (r_state == S_BUSY);
  assign bus.mul_result = r_result;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_ctrl -- directed testbench for mul_ctrl.
// A driver issues multiplies and pushes the hand-computed product, latency
// and ready-duration into queues; a monitor pops and checks them whenever
// mul_ready rises or falls.
// ---------------------------------------------------------------------------
module tb_mul_ctrl;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mul_ctrl_if bus ();

  mul_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------ scoreboard state
  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           dur_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] last_prod = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int early);
    return EARLY ? early : 64;
  endfunction

  // ------------------------------------------------ monitor
  int           busy_cnt = 0;
  int           rdy_cnt  = 0;
  logic         prev_rdy = 1'b0;
  logic [127:0] cur_exp  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
      rdy_cnt  = 0;
      prev_rdy = 1'b0;
    end else begin
      if (bus.mul_busy) busy_cnt++;
      if (bus.mul_ready) begin
        if (!prev_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 128'd1, 128'd0);
            cur_exp = bus.mul_result;
          end else begin
            cur_exp = exp_q.pop_front();
            chk("latency", 128'(busy_cnt), 128'(lat_q.pop_front()));
          end
        end
        chk("result", bus.mul_result, cur_exp);
        rdy_cnt++;
      end else if (prev_rdy) begin
        if (dur_q.size() != 0) chk("ready_cycles", 128'(rdy_cnt), 128'(dur_q.pop_front()));
        rdy_cnt  = 0;
        busy_cnt = 0;
      end else if (!bus.mul_busy) begin
        busy_cnt = 0;
      end
      prev_rdy = bus.mul_ready;
    end
  end

  // ------------------------------------------------ driver tasks
  // Presents a request; the next rising edge accepts it.
  task automatic drive_req(input logic sg, input logic [63:0] a, input logic [63:0] b,
                           input logic [127:0] exp, input int early, input int stall);
    bus.mul_valid  = 1'b1;
    bus.mul_signed = sg;
    bus.mul_op1    = a;
    bus.mul_op2    = b;
    bus.ex_stall   = (stall > 0);
    exp_q.push_back(exp);
    lat_q.push_back(lat_of(early));
    dur_q.push_back(stall + 1);
  endtask

  // Waits for the accept edge, scrambles operands, waits for ready,
  // holds mul_valid through DONE and checks the instruction is not re-taken.
  task automatic complete(input int stall);
    int n;
    @(posedge clk); #1;
    bus.mul_valid  = 1'b0;
    bus.mul_op1    = ~bus.mul_op1;
    bus.mul_op2    = ~bus.mul_op2 ^ 64'h5;
    bus.mul_signed = ~bus.mul_signed;
    n = 0;
    while (!bus.mul_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mul_ready) begin
      chk("ready_timeout", 128'd0, 128'd1);
    end else begin
      bus.mul_valid = 1'b1;
      if (stall > 0) begin
        repeat (stall) @(posedge clk);
        #1 bus.ex_stall = 1'b0;
      end
      @(posedge clk); #1;
      bus.mul_valid = 1'b0;
      @(negedge clk);
      chk("no_reaccept_busy", 128'(bus.mul_busy), 128'd0);
      chk("back_to_idle", 128'(dbg_state), 128'd0);
    end
    last_prod = exp_q.size() == 0 ? cur_exp : last_prod;
  endtask

  task automatic run_mul(input logic sg, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] exp, input int early, input int stall);
    @(posedge clk); #1;
    drive_req(sg, a, b, exp, early, stall);
    complete(stall);
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    int n;
    rst            = 1'b0;
    bus.mul_valid  = 1'b0;
    bus.mul_signed = 1'b0;
    bus.mul_op1    = '0;
    bus.mul_op2    = '0;
    bus.ex_stall   = 1'b0;
    bus.flush      = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(bus.mul_ready), 128'd0);
    chk("rst_busy", 128'(bus.mul_busy), 128'd0);
    chk("rst_result", bus.mul_result, 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Directed products.
    run_mul(1'b0, 64'd3, 64'd5, 128'd15, 3, 0);
    run_mul(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 2, 0);
    run_mul(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64, 0);
    run_mul(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
            128'h4000_0000_0000_0000_0000_0000_0000_0000, 64, 0);
    run_mul(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9, 1, 0);
    run_mul(1'b0, 64'h8000_0000_0000_0001, 64'd3, 128'h1_8000_0000_0000_0003, 2, 0);
    run_mul(1'b0, 64'd12345, 64'd0, 128'd0, 1, 0);

    // EX stalled for three cycles on DONE entry.
    run_mul(1'b0, 64'd100, 64'd200, 128'd20000, 8, 3);
    last_prod = 128'd20000;

    // Flush on the edge that would complete iteration 10.
    @(posedge clk); #1;
    bus.mul_valid  = 1'b1;
    bus.mul_signed = 1'b0;
    bus.mul_op1    = 64'd5;
    bus.mul_op2    = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    bus.mul_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    chk("flush_busy_before", 128'(bus.mul_busy), 128'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    drive_req(1'b0, 64'd6, 64'd7, 128'd42, 3, 0);
    @(negedge clk);
    chk("flush_busy_after", 128'(bus.mul_busy), 128'd0);
    chk("flush_ready", 128'(bus.mul_ready), 128'd0);
    chk("flush_result_held", bus.mul_result, last_prod);
    complete(0);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    bus.mul_valid = 1'b1;
    bus.mul_op1   = 64'd9;
    bus.mul_op2   = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_busy", 128'(bus.mul_busy), 128'd0);
    chk("async_rst_ready", 128'(bus.mul_ready), 128'd0);
    chk("async_rst_result", bus.mul_result, 128'd0);
    chk("async_rst_state", 128'(dbg_state), 128'd0);
    bus.mul_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_pending", 128'(bus.mul_busy), 128'd0);

    // Still operational after reset.
    run_mul(1'b0, 64'd3, 64'd5, 128'd15, 3, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named as below.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 mul_valid  input  1  EX holds a multiply instruction (mul/mulh/mulw).
REQ-005 mul_signed  input  1  1 = both operands signed (mulh); 0 = unsigned.
REQ-006 mul_op1  input  64  multiplicand.
REQ-007 mul_op2  input  64  multiplier.
REQ-008 ex_stall  input  1  EX is held by a source other than this block.
REQ-009 flush  input  1  kills the instruction currently in EX.
REQ-010 mul_ready  output  1  mul_result is valid for the instruction in EX.
REQ-011 mul_result  output  128  full product; EX selects [63:0], [127:64] or sign-extended [31:0].
REQ-012 mul_busy  output  1  high while state is BUSY.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE->BUSY SHALL occur on an edge with mul_valid=1 and flush=0; that edge latches the operands and mul_signed.
REQ-015 On accept, the block SHALL latch operand magnitudes (two's-complement negation when mul_signed and bit 63 set) and latch sign = op1[63]^op2[63] when signed, else 0.
REQ-016 Operand input changes after accept SHALL be ignored until the next accept.
REQ-017 BUSY SHALL perform radix-2 shift-add: when the multiplier LSB is 1, the 128-bit multiplicand is added to the accumulator; the multiplicand shifts left 1 and the multiplier shifts right 1; a 6-bit counter increments.
REQ-018 BUSY->DONE SHALL occur on the edge completing iteration 64, so mul_ready rises after the 64th edge following the accept edge.
REQ-019 On BUSY->DONE, mul_result SHALL be loaded with the accumulator, negated (two's complement, 128-bit) when the latched sign is 1.
REQ-020 In DONE, mul_ready SHALL be 1 and mul_result SHALL be held.
REQ-021 DONE->IDLE SHALL occur on the first edge with ex_stall=0, because the instruction leaves EX on that edge.
REQ-022 DONE SHALL NOT accept a new request, even with mul_valid=1.
REQ-023 In IDLE, mul_ready SHALL be 0.
REQ-024 A back-to-back multiply SHALL be accepted in the cycle after DONE->IDLE.
REQ-025 flush=1 in any state SHALL force IDLE on the next edge; no accept occurs on that edge, and mul_ready stays 0 for the killed instruction.
REQ-026 mul_result SHALL hold the last completed product outside DONE; a flush SHALL NOT alter it.
REQ-027 An operand of -2^63 SHALL use magnitude 2^63 as 64-bit unsigned; (-2^63)*(-2^63) SHALL give 2^126.

Reset
REQ-028 Assertion of rst SHALL immediately force state IDLE, mul_ready=0, mul_busy=0, mul_result=0, counter=0, accumulator=0, regardless of the current state.
REQ-029 Reset released mid-operation SHALL leave no pending request; EX must re-present mul_valid.

Configuration
REQ-030 With MUL_EARLY_EXIT_EN defined, BUSY->DONE SHALL also occur on the edge where the post-shift multiplier register equals 0, so latency = max(1, index of highest set bit of |op2| + 1) edges.
REQ-031 With MUL_EARLY_EXIT_EN undefined, latency SHALL be fixed at 64 BUSY edges for all operands.

Verification
REQ-032 Unsigned 3*5, ex_stall=0 -> mul_ready high only in the cycle after edge 64 (macro off), mul_result=15, then IDLE.
REQ-033 Signed -2*3 -> mul_result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA.
REQ-034 Unsigned 64'hFFFF_FFFF_FFFF_FFFF squared -> 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64 edges even with MUL_EARLY_EXIT_EN.
REQ-035 Flush during BUSY iteration 10 -> mul_busy=0 next cycle, mul_ready never rises, mul_result unchanged, next mul_valid accepted the cycle after.
REQ-036 ex_stall=1 for 3 cycles on DONE entry -> mul_ready and mul_result held 4 cycles, IDLE after the first ex_stall=0 edge, no re-accept of the same instruction.
REQ-037 MUL_EARLY_EXIT_EN: op2=3 -> ready after 2 edges with result 3*op1; op2=0 -> ready after 1 edge with result 0; async reset in BUSY -> all outputs 0 immediately.
